// File: rtl/f1_inverse_stream.sv
// Streaming inverse of y = (a + b) ^ c: recovers b from three packed lanes, flags lane disagreement,
// and keeps saturating hand-off statistics.
module f1_inverse_stream #(
  parameter int unsigned     W         = 4,
  parameter logic [W-1:0]    DEFAULT_C = W'(4'b1010),
  parameter int unsigned     CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*W-1:0]     in_y,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_b,
  output logic               out_mismatch,
  output logic [CNT_W-1:0]   count_words,
  output logic [CNT_W-1:0]   count_mismatch
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         s1_valid;
  logic [W-1:0] b0, b1, b2;
  logic         s2_adv;
  logic         s1_adv;
  logic         in_fire;
  logic         out_fire;
  logic [W-1:0] dec0, dec1, dec2;

  // Undo the key, then subtract a modulo 2^W.
  function automatic logic [W-1:0] decode(input logic [W-1:0] y, input logic [W-1:0] c,
                                          input logic [W-1:0] a);
    decode = W'((y ^ c) - a);
  endfunction

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;
  assign out_fire = out_valid && out_ready;

  assign dec0 = decode(in_y[0*W +: W], in_c,      in_a);
  assign dec1 = decode(in_y[1*W +: W], DEFAULT_C, in_a);
  assign dec2 = decode(in_y[2*W +: W], DEFAULT_C, in_a);

  // Stage 1: per-lane decode, loaded only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      b0       <= '0;
      b1       <= '0;
      b2       <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (in_fire) begin
        b0 <= dec0;
        b1 <= dec1;
        b2 <= dec2;
      end
    end
  end

  // Stage 2: result and lane-agreement flag; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_b        <= '0;
      out_mismatch <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_b        <= b0;
        out_mismatch <= (b0 != b1) || (b1 != b2);
      end
    end
  end

  // Hand-off statistics, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_words    <= '0;
      count_mismatch <= '0;
    end else if (out_fire) begin
      if (count_words != CNT_MAX) count_words <= count_words + CNT_W'(1);
      if (out_mismatch && (count_mismatch != CNT_MAX))
        count_mismatch <= count_mismatch + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_f1_inverse_stream.sv
// Directed bench for f1_inverse_stream; a second instance with 2-bit counters covers saturation.
module tb_f1_inverse_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_y;
  logic [3:0]  in_a;
  logic [3:0]  in_c;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_b;
  logic        out_mismatch;
  logic [15:0] count_words;
  logic [15:0] count_mismatch;

  logic        in_ready2;
  logic        out_valid2;
  logic [3:0]  out_b2;
  logic        out_mismatch2;
  logic [1:0]  count_words2;
  logic [1:0]  count_mismatch2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  f1_inverse_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .in_a(in_a), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b),
    .out_mismatch(out_mismatch), .count_words(count_words), .count_mismatch(count_mismatch)
  );

  f1_inverse_stream #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_y(in_y),
    .in_a(in_a), .in_c(in_c), .out_valid(out_valid2), .out_ready(out_ready), .out_b(out_b2),
    .out_mismatch(out_mismatch2), .count_words(count_words2), .count_mismatch(count_mismatch2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] c, input logic [11:0] y);
    in_valid = v;
    in_a     = a;
    in_c     = c;
    in_y     = y;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 12'h000);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    check("rst_out_mismatch", 32'(out_mismatch), 32'd0);
    check("rst_count_words", 32'(count_words), 32'd0);
    check("rst_count_mismatch", 32'(count_mismatch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_in_ready_sat", 32'(in_ready2), 32'd1);

    // Basic word: b = (A^2)-3 = 5 in every lane.
    drive(1'b1, 4'h3, 4'h2, 12'h22A);
    step();
    drive(1'b0, 4'h0, 4'h0, 12'h000);
    check("basic_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_b", 32'(out_b), 32'd5);
    check("basic_mm", 32'(out_mismatch), 32'd0);
    step();
    check("basic_count", 32'(count_words), 32'd1);
    check("basic_drained", 32'(out_valid), 32'd0);

    // Wrap then mismatch, back-to-back: 2-15 = 3; lane 2 gives (9^A)-F = 4.
    drive(1'b1, 4'hF, 4'h0, 12'h882);
    step();
    drive(1'b1, 4'hF, 4'h0, 12'h982);
    step();
    drive(1'b0, 4'h0, 4'h0, 12'h000);
    check("wrap_b", 32'(out_b), 32'd3);
    check("wrap_mm", 32'(out_mismatch), 32'd0);
    step();
    check("mm_b", 32'(out_b), 32'd3);
    check("mm_flag", 32'(out_mismatch), 32'd1);
    step();
    check("mm_count_words", 32'(count_words), 32'd3);
    check("mm_count_mismatch", 32'(count_mismatch), 32'd1);

    // Backpressure: two words buffer, third waits, then all drain in order.
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 4'h2, 12'h22A);
    #1;
    check("bp_ready0", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 4'hF, 4'h0, 12'h882);
    check("bp_ready1", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 4'hF, 4'h0, 12'h982);
    check("bp_full", 32'(in_ready), 32'd0);
    step();
    check("bp_stall_valid", 32'(out_valid), 32'd1);
    check("bp_stall_b", 32'(out_b), 32'd5);
    step();
    check("bp_stall2_b", 32'(out_b), 32'd5);
    check("bp_stall2_mm", 32'(out_mismatch), 32'd0);
    check("bp_stall2_ready", 32'(in_ready), 32'd0);
    check("bp_stall_count", 32'(count_words), 32'd3);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 4'h0, 4'h0, 12'h000);
    check("bp_w2_b", 32'(out_b), 32'd3);
    check("bp_w2_mm", 32'(out_mismatch), 32'd0);
    step();
    check("bp_w3_valid", 32'(out_valid), 32'd1);
    check("bp_w3_b", 32'(out_b), 32'd3);
    check("bp_w3_mm", 32'(out_mismatch), 32'd1);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_count_words", 32'(count_words), 32'd6);
    check("bp_count_mismatch", 32'(count_mismatch), 32'd2);

    // Reset with two words buffered drops them.
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 4'h2, 12'h22A);
    step();
    step();
    drive(1'b0, 4'h0, 4'h0, 12'h000);
    check("mid_buffered", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_count_words", 32'(count_words), 32'd0);
    check("mid_count_mismatch", 32'(count_mismatch), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    step();
    check("mid_no_stale", 32'(out_valid), 32'd0);

    // Saturation: five mismatching words, 2-bit counters stop at 3.
    drive(1'b1, 4'hF, 4'h0, 12'h982);
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 4'h0, 4'h0, 12'h000);
    for (int i = 0; i < 3; i++) step();
    check("sat_count_words", 32'(count_words2), 32'd3);
    check("sat_count_mismatch", 32'(count_mismatch2), 32'd3);
    check("sat_wide_words", 32'(count_words), 32'd5);
    check("sat_wide_mismatch", 32'(count_mismatch), 32'd5);
    check("sat_b", 32'(out_b2), 32'd3);
    check("sat_mm", 32'(out_mismatch2), 32'd1);
    check("sat_drained", 32'(out_valid2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
